nios2_video_clk_nco: RTL
========================

# nios2_video_clk_nco

Multi-channel, runtime-retunable clock-enable generator for the VGA subsystem. It is the parametrised successor to the fixed-ratio video PLL wrapper. Each of `NUM_CLKS` channels runs a phase accumulator on `refclk` and emits a one-cycle enable tick plus an MSB square wave. Per-channel frequency is set by an increment word that software rewrites glitch-free at a period boundary. `locked` reports that every channel has settled on its programmed rate.

## Interface
Parameters:
- `NUM_CLKS`, 3: number of output channels (1..16).
- `ACC_W`, 32: accumulator and increment width.
- `INCR_INIT`, {32'hA8F5C28F, 32'h80000000, 32'h80000000}: packed `NUM_CLKS*ACC_W` reset increments. Channel 0 is in the LSBs. At 50 MHz these give 25, 25 and 33 MHz.
- `LOCK_CYCLES`, 256: settle cycles before `locked` rises (≥1).

Ports:
- `refclk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_wr`, in, 1: write strobe for a new increment.
- `cfg_sel`, in, 4: target channel; values ≥ `NUM_CLKS` are ignored.
- `cfg_incr`, in, `ACC_W`: new increment; 0 disables the channel.
- `phase_sync`, in, 1: one-cycle pulse that zeroes all accumulators together.
- `outclk_en`, out, `NUM_CLKS`: per-channel one-cycle tick at f_ref·incr/2^ACC_W.
- `outclk`, out, `NUM_CLKS`: accumulator MSB. It is a 50%-ish square wave, valid only when incr ≤ 2^(ACC_W-1).
- `pending`, out, `NUM_CLKS`: a staged increment is awaiting application.
- `locked`, out, 1: all channels are stable.

## Operation
- Channel i keeps `acc_i`, `incr_i`, `pend_val_i` and `pend_i`.
  - Each edge: {carry, acc_i} ← acc_i + incr_i.
  - `outclk_en[i]` ← carry (registered).
  - `outclk[i]` = acc_i[ACC_W-1].
- Retune:
  - `cfg_wr` with a valid `cfg_sel` loads `pend_val` and sets `pend`.
  - With `pend` set, the next edge on which that channel's add carries loads `incr` ← `pend_val` and clears `pend`. The carrying add still uses the old increment.
  - If the current incr = 0, the pending value applies on the next edge after `pend` is set, with no carry needed.
- Boundary rules:
  - A write while `pend` is set overwrites `pend_val`.
  - A write on the same edge as an apply: the old `pend_val` is applied, the new value is staged, and `pend` stays 1.
  - Incr = 0 holds `acc`, so `outclk_en` = 0 and `outclk` is frozen. A `phase_sync` then forces `outclk` to 0.
  - A wrap past 2^ACC_W is modular and needs no special case.
- `phase_sync`:
  - All `acc` ← 0 on the next edge; that edge produces no tick.
  - `pend` and `incr` are unaffected.
  - `phase_sync` together with `cfg_wr`: both take effect.
- Lock:
  - A counter of width clog2(LOCK_CYCLES+1) clears on `rst`, on a valid `cfg_wr`, on `phase_sync`, or while any `pend` is set.
  - Otherwise it increments, saturating at LOCK_CYCLES.
  - `locked` = registered (count == LOCK_CYCLES).
- Reset values:
  - acc = 0, incr = INCR_INIT, pend = 0.
  - `outclk_en` = 0, `outclk` = 0, `pending` = 0, `locked` = 0.
  - `rst` asserted mid-operation discards staged writes.

## Timing
- Tick latency: for incr = 2^(ACC_W-1), `outclk_en` is first high on the 2nd edge after `rst` falls, then every 2 cycles. `outclk` is 1 on the 1st edge, then alternates.
- Retune latency: the write is registered at edge k. The apply happens at the first carry edge > k, at most ⌈2^ACC_W/incr_old⌉ cycles later.
- `pending[i]` rises at edge k and falls on the apply edge.
- `locked` falls one edge after a valid `cfg_wr` or `phase_sync`. It rises LOCK_CYCLES+1 edges after the last `pend` clears.
- Throughput: one `cfg_wr` is accepted per cycle. There is no backpressure and writes are never refused.

## Structure
- Package `nios2_video_clk_pkg` holds:
  - `ACC_W_DEF`.
  - `INCR_25M_AT_50M` = 32'h80000000 and `INCR_33M_AT_50M` = 32'hA8F5C28F.
  - Constant function `incr_for(f_out_hz, f_ref_hz)`.
- Sub-module `nios2_video_nco_channel` holds one accumulator, the pending stage, the tick and the MSB. It is generated `NUM_CLKS` times.
- The top level keeps the cfg decode and the lock counter.

## Test plan
- Reset with the defaults, 50 MHz ref → channels 0 and 1 tick every 2 cycles; channel 2 gives 33 ticks per 50 cycles (±1); `locked` is high at cycle 257.
- Write 32'h40000000 to channel 0 mid-period → the old rate holds until the next carry, then ticks come every 4 cycles; `pending[0]` spans exactly that gap; `locked` drops, then returns 257 cycles after the apply.
- Two writes 32'h20000000 then 32'h10000000 before a carry → only 32'h10000000 takes effect, giving ticks every 16 cycles.
- Write 0 to channel 1 → ticks stop after the next carry and `outclk[1]` is frozen. Then write 32'h80000000 → it applies one edge after being staged.
- `phase_sync` with channels at 2/4/16-cycle periods → all accumulators read 0, no tick on the sync edge, then channel ticks align at cycles 2, 4 and 16.
- `rst` asserted while `pend` is set → `pending` = 0, incr = INCR_INIT, `locked` = 0; the staged value is never applied. A `cfg_sel` of 5 with `NUM_CLKS`=3 → no state change, `locked` undisturbed.

Source files
------------

// File: rtl/nios2_video_clk_pkg.sv
// rtl/nios2_video_clk_pkg.sv - shared constants and increment helper for the video clock NCO
package nios2_video_clk_pkg;

  // Default accumulator / increment width
  localparam int ACC_W_DEF = 32;

  // Increments for a 50 MHz reference clock
  localparam logic [ACC_W_DEF-1:0] INCR_25M_AT_50M = 32'h80000000;
  localparam logic [ACC_W_DEF-1:0] INCR_33M_AT_50M = 32'hA8F5C28F;

  // Increment word type for the default width
  typedef logic [ACC_W_DEF-1:0] incr_t;

  // Increment that makes an ACC_W_DEF-bit accumulator carry at f_out_hz when
  // clocked at f_ref_hz: floor(f_out * 2^ACC_W / f_ref).  The intermediate is
  // 64 bits wide, so f_out_hz must stay below 2^32.
  function automatic incr_t incr_for(input longint unsigned f_out_hz,
                                     input longint unsigned f_ref_hz);
    logic [63:0] scaled;
    scaled = (64'(f_out_hz) << ACC_W_DEF) / 64'(f_ref_hz);
    return scaled[ACC_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/nios2_video_nco_channel.sv
// rtl/nios2_video_nco_channel.sv - one phase accumulator with a glitch-free staged increment
module nios2_video_nco_channel
  import nios2_video_clk_pkg::*;
#(
  parameter int              ACC_W    = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INCR_RST = INCR_25M_AT_50M[ACC_W-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_incr,
  input  logic             sync,
  output logic             tick,
  output logic             msb,
  output logic             pend
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] incr;
  logic [ACC_W-1:0] pend_val;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  // Next accumulator value with its carry, and whether the staged word lands
  // on this edge.  A sync edge discards the add, so its carry is not a period
  // boundary; a stopped channel (incr == 0) has no boundary at all and takes
  // the staged word right away.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, incr};
    carry = sum[ACC_W] & ~sync;
    apply = pend & (carry | (incr == '0));
  end

  // Accumulator, tick and retune staging; a write on an apply edge stages the
  // new word after the old one has been consumed, so pend stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      incr     <= INCR_RST;
      pend_val <= '0;
      pend     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (sync) begin
        acc  <= '0;
        tick <= 1'b0;
      end else begin
        acc  <= sum[ACC_W-1:0];
        tick <= sum[ACC_W];
      end
      if (apply) begin
        incr <= pend_val;
        pend <= 1'b0;
      end
      if (wr) begin
        pend_val <= wr_incr;
        pend     <= 1'b1;
      end
    end
  end

  assign msb = acc[ACC_W-1];

endmodule

// File: rtl/nios2_video_clk_nco.sv
// rtl/nios2_video_clk_nco.sv - multi-channel retunable clock-enable generator with lock indication
module nios2_video_clk_nco
  import nios2_video_clk_pkg::*;
#(
  parameter int                        NUM_CLKS    = 3,
  parameter int                        ACC_W       = ACC_W_DEF,
  parameter logic [NUM_CLKS*ACC_W-1:0] INCR_INIT   = {INCR_33M_AT_50M, INCR_25M_AT_50M, INCR_25M_AT_50M},
  parameter int                        LOCK_CYCLES = 256
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [3:0]          cfg_sel,
  input  logic [ACC_W-1:0]    cfg_incr,
  input  logic                phase_sync,
  output logic [NUM_CLKS-1:0] outclk_en,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] pending,
  output logic                locked
);

  localparam int              CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  logic                sel_valid;
  logic                wr_valid;
  logic [NUM_CLKS-1:0] wr_vec;
  logic                lock_clr;
  logic [CNT_W-1:0]    lock_cnt;

  // Decode the write strobe to a one-hot channel; out-of-range selects are dropped
  always_comb begin
    sel_valid = ({1'b0, cfg_sel} < 5'(NUM_CLKS));
    wr_valid  = cfg_wr & sel_valid;
    wr_vec    = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      wr_vec[i] = wr_valid & (cfg_sel == 4'(i));
    end
    lock_clr  = wr_valid | phase_sync | (|pending);
  end

  // Settle counter: restarts on any disturbance, saturates at LOCK_CYCLES
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      locked <= (lock_cnt == LOCK_MAX);
      if (lock_clr) begin
        lock_cnt <= '0;
      end else if (lock_cnt != LOCK_MAX) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CLKS; g++) begin : g_ch
    nios2_video_nco_channel #(
      .ACC_W    (ACC_W),
      .INCR_RST (INCR_INIT[g*ACC_W +: ACC_W])
    ) u_ch (
      .clk     (refclk),
      .rst     (rst),
      .wr      (wr_vec[g]),
      .wr_incr (cfg_incr),
      .sync    (phase_sync),
      .tick    (outclk_en[g]),
      .msb     (outclk[g]),
      .pend    (pending[g])
    );
  end

endmodule
